// File: rtl/inv_sub_bytes_engine.sv
// Iterative AES InvSubBytes: substitutes LANES bytes of a 128-bit state per clock
// between a valid/ready input handshake and a valid/ready output handshake.
module inv_sub_bytes_engine #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);
    localparam int unsigned Beats = 16 / LANES;
    localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

    // Inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] InvSbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [15:0][7:0] st_q, st_d;  // st_q[15] holds byte 0
    logic            in_ready_q, out_valid_q, busy_q;

    function automatic logic [7:0] inv_s(input logic [7:0] x);
        return InvSbox[{~x, 3'b000} +: 8];
    endfunction

    always_comb begin
        logic [3:0] idx;
        idx  = '0;
        st_d = st_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            idx       = 4'(32'd15 - (32'(cnt_q) * LANES + l));
            st_d[idx] = inv_s(st_q[idx]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            st_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        st_q       <= data_in;
                        cnt_q      <= '0;
                        state_q    <= StBusy;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                StBusy: begin
                    st_q <= st_d;
                    if (cnt_q == LastCnt) begin
                        cnt_q       <= '0;
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign data_out  = st_q;

endmodule

// File: tb/tb_inv_sub_bytes_engine.sv
// Directed bench for inv_sub_bytes_engine: LANES=4 main instance plus LANES=1 and
// LANES=16 instances for the latency variants; expectations from a forward S-box model.
module tb_inv_sub_bytes_engine;

    localparam logic [2047:0] FwdSbox = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Accept edge, 4 BUSY beats, DONE handshake edge, IDLE accept edge.
    localparam int BackToBackPeriod = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, iv_side, out_ready;
    logic [127:0] data_in;
    logic         in_ready, out_valid, busy;
    logic [127:0] data_out;
    logic         l1_in_ready, l1_out_valid, l1_busy;
    logic [127:0] l1_data_out;
    logic         l16_in_ready, l16_out_valid, l16_busy;
    logic [127:0] l16_data_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inv_sub_bytes_engine #(.LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .busy(busy)
    );

    inv_sub_bytes_engine #(.LANES(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_side), .in_ready(l1_in_ready),
        .data_in(data_in), .out_valid(l1_out_valid), .out_ready(1'b1),
        .data_out(l1_data_out), .busy(l1_busy)
    );

    inv_sub_bytes_engine #(.LANES(16)) dut_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_side), .in_ready(l16_in_ready),
        .data_in(data_in), .out_valid(l16_out_valid), .out_ready(1'b1),
        .data_out(l16_data_out), .busy(l16_busy)
    );

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fwd_s(input logic [7:0] x);
        return FwdSbox[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [127:0] fwd_state(input logic [127:0] p);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) r[127-8*j -: 8] = fwd_s(p[127-8*j -: 8]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction into all three instances at once; all must be idle on entry.
    task automatic txn_all(input string tag, input logic [127:0] d, input logic [127:0] exp);
        int lat4, lat1, lat16;
        lat4 = -1; lat1 = -1; lat16 = -1;
        check_eq({tag, ":ready"}, {125'd0, in_ready, l1_in_ready, l16_in_ready}, 128'd7);
        data_in  = d;
        in_valid = 1'b1;
        iv_side  = 1'b1;
        tick();
        in_valid = 1'b0;
        iv_side  = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (out_valid && lat4 < 0) begin
                lat4 = c;
                check_eq({tag, ":data_l4"}, data_out, exp);
            end
            if (l1_out_valid && lat1 < 0) begin
                lat1 = c;
                check_eq({tag, ":data_l1"}, l1_data_out, exp);
            end
            if (l16_out_valid && lat16 < 0) begin
                lat16 = c;
                check_eq({tag, ":data_l16"}, l16_data_out, exp);
            end
        end
        check_eq({tag, ":lat_l4"}, 128'(lat4), 128'd4);
        check_eq({tag, ":lat_l1"}, 128'(lat1), 128'd16);
        check_eq({tag, ":lat_l16"}, 128'(lat16), 128'd1);
    endtask

    task automatic wait_out_valid(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check_eq({tag, ":out_valid"}, {127'd0, out_valid}, 128'd1);
    endtask

    logic [127:0] bin  [8];
    logic [127:0] bexp [8];

    initial begin
        logic [127:0] p, a_exp, b_exp;
        int lat, seen;

        rst_n = 1'b1; in_valid = 1'b0; iv_side = 1'b0; out_ready = 1'b1; data_in = '0;
        #1 rst_n = 1'b0;
        #11;
        check_eq("rst_flags", {125'd0, in_ready, out_valid, busy}, 128'd4);
        check_eq("rst_data", data_out, 128'd0);
        check_eq("rst_side_flags",
                 {124'd0, l1_in_ready, l1_out_valid, l16_in_ready, l16_out_valid}, 128'ha);
        #10 rst_n = 1'b1;
        tick();

        txn_all("fips", 128'h637c777bf26b6fc53001672bfed7ab76,
                128'h000102030405060708090a0b0c0d0e0f);
        txn_all("all00", 128'h0, {16{8'h52}});
        txn_all("all16", {16{8'h16}}, {16{8'hff}});
        txn_all("all52", {16{8'h52}}, {16{8'h48}});
        txn_all("mixed", {4{32'h63001652}}, {4{32'h0052ff48}});

        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 16; j++) p[127-8*j -: 8] = 8'(16 * k + j);
            txn_all($sformatf("rt%0d", k), fwd_state(p), p);
        end

        // Backpressure: second state held on in_valid while the first sits in DONE.
        a_exp = 128'h00112233445566778899aabbccddeeff;
        b_exp = 128'hfedcba98765432100123456789abcdef;
        out_ready = 1'b0;
        data_in   = fwd_state(a_exp);
        in_valid  = 1'b1;
        tick();
        data_in = fwd_state(b_exp);
        wait_out_valid("bp_a", lat);
        for (int c = 0; c < 10; c++) begin
            check_eq("bp_hold_data", data_out, a_exp);
            check_eq("bp_hold_flags", {125'd0, in_ready, out_valid, busy}, 128'd3);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check_eq("bp_after_hs", {125'd0, in_ready, out_valid, busy}, 128'd4);
        tick();
        in_valid = 1'b0;
        check_eq("bp_b_accepted", {125'd0, in_ready, out_valid, busy}, 128'd1);
        wait_out_valid("bp_b", lat);
        check_eq("bp_b_lat", 128'(lat), 128'd4);
        check_eq("bp_b_data", data_out, b_exp);
        tick();

        // Reset while BUSY beat 2 is in progress.
        data_in  = fwd_state(a_exp);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("mrst_flags", {125'd0, in_ready, out_valid, busy}, 128'd4);
        check_eq("mrst_data", data_out, 128'd0);
        tick();
        #3 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (out_valid) seen++;
        end
        check_eq("mrst_no_out_valid", 128'(seen), 128'd0);
        txn_all("mrst_next", fwd_state(b_exp), b_exp);

        // Back-to-back with in_valid and out_ready held high.
        for (int i = 0; i < 8; i++) begin
            bexp[i] = {$urandom, $urandom, $urandom, $urandom};
            bin[i]  = fwd_state(bexp[i]);
        end
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    int g;
                    g        = 0;
                    data_in  = bin[i];
                    in_valid = 1'b1;
                    while (!in_ready && g < 50) begin
                        tick();
                        g++;
                    end
                    tick();
                end
                in_valid = 1'b0;
            end
            begin
                int k, cyc, last;
                k = 0; cyc = 0; last = 0;
                while (k < 8 && cyc < 200) begin
                    tick();
                    cyc++;
                    if (out_valid) begin
                        check_eq($sformatf("b2b_data%0d", k), data_out, bexp[k]);
                        if (k > 0)
                            check_eq($sformatf("b2b_period%0d", k), 128'(cyc - last),
                                     128'(BackToBackPeriod));
                        last = cyc;
                        k++;
                    end
                end
                check_eq("b2b_count", 128'(k), 128'd8);
            end
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
